// File: rtl/mem_stage.sv
// Memory pipeline stage: registers EX results, issues Dcache loads/stores, aligns
// store/load data and presents writeback fields once the access completes.
module mem_stage #(
   parameter int WAIT_TO = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ex_op_c_i,
   input  logic [4:0]  ex_reg_waddr_i,
   input  logic        ex_reg_we_i,
   input  logic        ex_mtype_i,
   input  logic        ex_mem_rw_i,
   input  logic [1:0]  ex_mem_width_i,
   input  logic [31:0] ex_mem_wr_data_i,
   input  logic        ex_mem_rdtype_i,
   input  logic        ex_mem_req_i,
   output logic        dcache_req_o,
   output logic        dcache_rw_o,
   output logic [31:0] dcache_addr_o,
   output logic [31:0] dcache_wdata_o,
   output logic [3:0]  dcache_wstrb_o,
   input  logic        dcache_gnt_i,
   input  logic        dcache_rvalid_i,
   input  logic [31:0] dcache_rdata_i,
   output logic        mem_stall_o,
   output logic        wb_valid_o,
   output logic [4:0]  wb_reg_waddr_o,
   output logic        wb_reg_we_o,
   output logic [31:0] wb_data_o,
   output logic        mem_err_o
);

   localparam int CNT_W = (WAIT_TO > 255) ? $clog2(WAIT_TO + 1) : 8;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(WAIT_TO - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
   state_t state, state_nxt;

   logic [31:0]      op_c_q, wr_data_q, load_q;
   logic [4:0]       reg_waddr_q;
   logic [1:0]       width_q;
   logic             reg_we_q, mtype_q, mem_rw_q, rdtype_q;
   logic             valid_q, err_q, err_pulse_q;
   logic [CNT_W-1:0] wd_cnt_q;
   logic             in_idle, in_req, mis, timeout, resp, is_store, is_load;

   function automatic logic misaligned(input logic [1:0] width, input logic [1:0] off);
      case (width)
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] width, input logic [31:0] d);
      case (width)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] store_strb(input logic [1:0] width, input logic [1:0] off);
      case (width)
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [1:0] width, input logic zext);
      logic [31:0]        sh;
      logic signed [31:0] sx;
      sh = rdata >> {off, 3'b000};
      case (width)
         2'b00: begin
            sx = 32'(signed'(sh[7:0]));
            return zext ? {24'b0, sh[7:0]} : sx;
         end
         2'b01: begin
            sx = 32'(signed'(sh[15:0]));
            return zext ? {16'b0, sh[15:0]} : sx;
         end
         default: return sh;
      endcase
   endfunction

   assign in_idle  = (state == ST_IDLE);
   assign in_req   = (state == ST_REQ);
   assign is_store = mtype_q & mem_rw_q;
   assign is_load  = mtype_q & ~mem_rw_q;
   assign mis      = ex_mtype_i & ex_mem_req_i & misaligned(ex_mem_width_i, ex_op_c_i[1:0]);
   assign timeout  = (WAIT_TO != 0) && (state == ST_WAIT) && !dcache_rvalid_i && (wd_cnt_q == TO_LAST);
   assign resp     = dcache_rvalid_i & ((in_req & dcache_gnt_i) | (state == ST_WAIT));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (ex_mtype_i & ex_mem_req_i & ~mis) state_nxt = ST_REQ;
         ST_REQ:  if (dcache_gnt_i) state_nxt = dcache_rvalid_i ? ST_IDLE : ST_WAIT;
         ST_WAIT: if (dcache_rvalid_i | timeout) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Stage register: capture in IDLE, hold while the access is outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         err_pulse_q <= 1'b0;
         wd_cnt_q    <= '0;
         op_c_q      <= '0;
         wr_data_q   <= '0;
         load_q      <= '0;
         reg_waddr_q <= '0;
         width_q     <= '0;
         reg_we_q    <= 1'b0;
         mtype_q     <= 1'b0;
         mem_rw_q    <= 1'b0;
         rdtype_q    <= 1'b0;
      end else begin
         state       <= state_nxt;
         err_pulse_q <= (in_idle & mis) | timeout;
         wd_cnt_q    <= (state == ST_WAIT) ? wd_cnt_q + 1'b1 : '0;
         if (in_idle) begin
            valid_q     <= 1'b1;
            err_q       <= mis;
            op_c_q      <= ex_op_c_i;
            wr_data_q   <= ex_mem_wr_data_i;
            reg_waddr_q <= ex_reg_waddr_i;
            width_q     <= ex_mem_width_i;
            reg_we_q    <= ex_reg_we_i;
            mtype_q     <= ex_mtype_i;
            mem_rw_q    <= ex_mem_rw_i;
            rdtype_q    <= ex_mem_rdtype_i;
         end else if (timeout) begin
            err_q <= 1'b1;
         end
         if (resp & ~mem_rw_q)
            load_q <= load_extend(dcache_rdata_i, op_c_q[1:0], width_q, rdtype_q);
      end
   end

   // Dcache request is only driven in REQ; writeback only in IDLE
   assign dcache_req_o   = in_req;
   assign dcache_rw_o    = in_req & mem_rw_q;
   assign dcache_addr_o  = in_req ? {op_c_q[31:2], 2'b00} : '0;
   assign dcache_wdata_o = (in_req & mem_rw_q) ? store_data(width_q, wr_data_q) : '0;
   assign dcache_wstrb_o = (in_req & mem_rw_q) ? store_strb(width_q, op_c_q[1:0]) : '0;

   assign mem_stall_o    = ~in_idle;
   assign wb_valid_o     = in_idle & valid_q;
   assign wb_reg_waddr_o = in_idle ? reg_waddr_q : '0;
   assign wb_reg_we_o    = in_idle & valid_q & reg_we_q & ~is_store & ~err_q;
   assign wb_data_o      = !in_idle ? '0 : (is_load ? load_q : op_c_q);
   assign mem_err_o      = err_pulse_q;

endmodule
